// File: rtl/stage_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_arb_pkg
// Summary  : Shared width constants and helpers for the stage output arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARB_NREQ
`define ARB_NREQ 4
`endif
`ifndef ARB_CREDITS
`define ARB_CREDITS 2
`endif

package stage_arb_pkg;

    // A link word carries the data plus its phi-valid tag.
    localparam int c_WORD_W = `DATA_WIDTH + 1;

    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Summary  : Combinational round-robin pick: first request after ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import stage_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_idx
);

    logic [NREQ-1:0] w_rot;
    int              w_off;

    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_rot[k] = req[wrap_add(int'(ptr), k + 1, NREQ)];
        end
        // Descending scan leaves the lowest rotated offset, i.e. the nearest requester.
        w_off = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        gnt_vld = |req;
        gnt_idx = IW'(wrap_add(int'(ptr), w_off + 1, NREQ));
    end

endmodule
`default_nettype wire

// File: rtl/stage_arb.sv
`default_nettype none
// ============================================================================
// Module   : stage_arb
// Summary  : Round-robin arbiter and credit controller for one shared output link.
// Revision : 1.0 - initial release
// ============================================================================
module stage_arb
    import stage_arb_pkg::*;
#(
    parameter int NREQ    = `ARB_NREQ,
    parameter int CREDITS = `ARB_CREDITS,
    parameter int CW      = 3,
    parameter int IW      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          ready_in,
    input  logic [NREQ-1:0]          valid_in,
    input  logic [NREQ*c_WORD_W-1:0] data_in,
    output logic [NREQ-1:0]          credit_out,
    input  logic                     credit_in,
    output logic                     ready_out,
    output logic [c_WORD_W-1:0]      data_out,
    output logic                     valid_out,
    output logic [IW-1:0]            grant_id,
    output logic [CW-1:0]            credit_cnt,
    output logic                     err
);

    localparam logic [CW-1:0] c_FULL = CW'(CREDITS);

    logic                r_ready;
    logic [c_WORD_W-1:0] r_data;
    logic                r_valid;
    logic [IW-1:0]       r_gid;
    logic [IW-1:0]       r_ptr;
    logic [CW-1:0]       r_cnt;
    logic                r_err;

    logic                w_any;
    logic                w_gnt;
    logic [IW-1:0]       w_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (ready_in),
        .ptr     (r_ptr),
        .gnt_vld (w_any),
        .gnt_idx (w_idx)
    );

    assign w_gnt = w_any && (r_cnt != '0) && !rst;

    always_comb begin
        credit_out = '0;
        if (w_gnt) begin
            credit_out[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_gid   <= '0;
            r_ptr   <= IW'(NREQ - 1);
            r_cnt   <= c_FULL;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_gnt;
            if (w_gnt) begin
                r_data  <= data_in[w_idx*c_WORD_W +: c_WORD_W];
                r_valid <= valid_in[w_idx];
                r_gid   <= w_idx;
                r_ptr   <= w_idx;
            end
            // A returned credit with nothing outstanding is a downstream protocol error.
            case ({w_gnt, credit_in})
                2'b10: r_cnt <= r_cnt - 1'b1;
                2'b01: begin
                    if (r_cnt == c_FULL) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign ready_out  = r_ready;
    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign grant_id   = r_gid;
    assign credit_cnt = r_cnt;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stage_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_arb
// Summary  : Self-checking bench for stage_arb against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module tb_stage_arb;

    localparam int NREQ    = 4;
    localparam int CREDITS = 2;
    localparam int CW      = 3;
    localparam int IW      = 2;
    localparam int DW      = `DATA_WIDTH + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      ready_in;
    logic [NREQ-1:0]      valid_in;
    logic [NREQ*DW-1:0]   data_in;
    logic [NREQ-1:0]      credit_out;
    logic                 credit_in;
    logic                 ready_out;
    logic [DW-1:0]        data_out;
    logic                 valid_out;
    logic [IW-1:0]        grant_id;
    logic [CW-1:0]        credit_cnt;
    logic                 err;

    stage_arb #(.NREQ(NREQ), .CREDITS(CREDITS), .CW(CW), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready_in   (ready_in),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .credit_out (credit_out),
        .credit_in  (credit_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .grant_id   (grant_id),
        .credit_cnt (credit_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what the link must look like after the last edge.
    int              m_cnt, m_ptr, m_gid;
    bit              m_err, m_rdy, m_vld;
    logic [DW-1:0]   m_data;
    logic [NREQ-1:0] obs_credit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] word(input int i);
        return data_in[i*DW +: DW];
    endfunction

    task automatic model_reset();
        m_cnt = CREDITS; m_ptr = NREQ - 1; m_gid = 0;
        m_err = 0; m_rdy = 0; m_vld = 0; m_data = '0;
    endtask

    // Compare all outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        int win;
        logic [NREQ-1:0] exp_co;
        #2;
        win = (!rst && m_cnt > 0) ? pick(ready_in, m_ptr) : -1;
        exp_co = '0;
        if (win >= 0) exp_co[win] = 1'b1;
        chk("credit_out", 64'(credit_out), 64'(exp_co));
        chk("ready_out",  64'(ready_out),  64'(m_rdy));
        chk("data_out",   64'(data_out),   64'(m_data));
        chk("valid_out",  64'(valid_out),  64'(m_vld));
        chk("grant_id",   64'(grant_id),   64'(m_gid));
        chk("credit_cnt", 64'(credit_cnt), 64'(m_cnt));
        chk("err",        64'(err),        64'(m_err));
        obs_credit = credit_out;
        if (rst) begin
            model_reset();
        end else begin
            m_rdy = (win >= 0);
            if (win >= 0) begin
                m_data = word(win); m_vld = valid_in[win];
                m_gid = win; m_ptr = win;
            end
            if (win >= 0 && !credit_in) m_cnt = m_cnt - 1;
            else if (win < 0 && credit_in) begin
                if (m_cnt == CREDITS) m_err = 1;
                else m_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; ready_in = '0; credit_in = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; ready_in = '0; valid_in = '0; data_in = '0; credit_in = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Reset state and first grant
        chk("rst_cnt", 64'(credit_cnt), 64'd2);
        chk("rst_ready_out", 64'(ready_out), 64'd0);
        ready_in = 4'b0001; valid_in = 4'b0001;
        data_in[0 +: DW] = DW'(32'h11);
        tick();
        chk("first_credit", 64'(obs_credit), 64'b0001);
        ready_in = '0;
        tick();
        chk("first_data", 64'(data_out), 64'h11);
        chk("first_cnt", 64'(credit_cnt), 64'd1);

        // All ready with a credit returned every cycle
        do_reset();
        ready_in = 4'b1111; credit_in = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rr_order", 64'(obs_credit), 64'(4'b0001 << (c % 4)));
        end
        credit_in = 0; ready_in = '0;
        chk("rr_cnt", 64'(credit_cnt), 64'd2);

        // Credits run out, then one credit returns
        do_reset();
        ready_in = 4'b0110;
        tick(); chk("dry_g1", 64'(obs_credit), 64'b0010);
        tick(); chk("dry_g2", 64'(obs_credit), 64'b0100);
        tick(); chk("dry_none", 64'(obs_credit), 64'b0000);
        chk("dry_cnt", 64'(credit_cnt), 64'd0);
        credit_in = 1;
        tick(); chk("dry_nobypass", 64'(obs_credit), 64'b0000);
        credit_in = 0;
        tick(); chk("dry_resume", 64'(obs_credit), 64'b0010);
        credit_in = 1;
        tick(); chk("dry_cnt0", 64'(credit_cnt), 64'd1);
        // Grant and credit together at cnt=1
        tick(); chk("both_gnt", 64'(obs_credit), 64'b0100);
        chk("both_cnt", 64'(credit_cnt), 64'd1);
        credit_in = 0; ready_in = '0;

        // Overflow is sticky until reset
        do_reset();
        credit_in = 1;
        tick();
        credit_in = 0;
        chk("ovf_cnt", 64'(credit_cnt), 64'd2);
        chk("ovf_err", 64'(err), 64'd1);
        tick(); tick();
        chk("ovf_sticky", 64'(err), 64'd1);

        // Reset while drained with a word on the link
        do_reset();
        ready_in = 4'b1111;
        tick(); tick();
        chk("pre_rst_cnt", 64'(credit_cnt), 64'd0);
        chk("pre_rst_rdy", 64'(ready_out), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_rdy", 64'(ready_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_cnt2", 64'(credit_cnt), 64'd2);
        ready_in = 4'b1000;
        tick(); chk("rst_ptr", 64'(obs_credit), 64'b1000);
        ready_in = 4'b1001;
        tick(); chk("rst_ptr_wrap", 64'(obs_credit), 64'b0001);

        // Randomized traffic honouring the requester hold-until-credit protocol
        ready_in = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            credit_in = ($urandom_range(0, 99) < 45);
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (obs_credit[i] || !ready_in[i] || rst) begin
                    ready_in[i] = ($urandom_range(0, 2) != 0);
                    valid_in[i] = $urandom_range(0, 1);
                    data_in[i*DW +: DW] = DW'({$urandom, $urandom});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_arb.md
Name: stage_arb

Overview:
- Round-robin arbiter and credit controller sharing one credit-flow-controlled output link between NREQ upstream producers.
- Typical producers are the stage outputs feeding a single DySER output port.
- Tracks downstream credits, grants one ready requester per cycle when a credit is available, and registers the winner's data/valid onto the shared link.
- Returns a one-cycle credit pulse to the winner.

Parameters:
- NREQ, 4, number of requesters (2..16).
- CREDITS, 2, credit count loaded at reset; equals downstream buffer depth.
- CW, 3, credit counter width; must satisfy 2^CW > CREDITS.
- IW, 2, grant index width, clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready_in  in  NREQ  bit i: requester i holds a valid word.
- valid_in  in  NREQ  bit i: phi-valid tag of requester i's word.
- data_in  in  NREQ*(`DATA_WIDTH+1)  requester i's word at slice [i*(`DATA_WIDTH+1) +: `DATA_WIDTH+1].
- credit_out  out  NREQ  one-cycle pulse to requester i when its word is taken.
- credit_in  in  1  one-cycle pulse from downstream returning one credit.
- ready_out  out  1  one-cycle pulse: data_out/valid_out hold a new word.
- data_out  out  `DATA_WIDTH+1  registered winner data.
- valid_out  out  1  registered winner valid tag.
- grant_id  out  IW  index of the last winner (registered).
- credit_cnt  out  CW  current credit count.
- err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (rst=1 at clk edge): ready_out=0, data_out=0, valid_out=0, grant_id=0, err=0, credit_cnt=CREDITS, rr pointer=NREQ-1 (requester 0 has first priority).
- credit_out is combinational and is 0 whenever rst=1.
- Grant condition each cycle: any ready_in bit set AND credit_cnt>0.
- Winner: first set ready_in bit searching from (ptr+1) mod NREQ upward, with wrap-around.
- On grant, same cycle: credit_out[winner]=1 (Mealy). All other credit_out bits are 0.
- On grant, next edge:
  - data_out <= winner data, valid_out <= winner valid.
  - ready_out <= 1, grant_id <= winner, ptr <= winner.
- Latency: requester ready to ready_out is 1 cycle.
- Throughput: 1 word/cycle while credits remain.
- No grant: ready_out <= 0. data_out, valid_out, grant_id and ptr hold.
- Credit accounting, next edge:
  - grant only: cnt-1.
  - credit_in only: cnt+1.
  - both: unchanged.
  - neither: unchanged.
- credit_in with cnt==CREDITS and no grant: cnt holds at CREDITS (saturate) and err <= 1. err clears only on rst.
- cnt==0: no grant is issued even if all ready_in bits are set. A credit_in in that cycle raises cnt to 1, so a grant is possible next cycle (no same-cycle bypass).
- Requester protocol: a requester keeps ready_in/data_in stable until it sees credit_out, then deasserts or presents its next word the following cycle.
- Single requester: granted every cycle while credits remain; ptr stays at its index.
- Reset mid-transfer: in-flight word is discarded and credits return to CREDITS. Upstream stages must be reset in the same cycle.

Decomposition:
- Add to dyser_config.v: `ARB_NREQ and `ARB_CREDITS defaults.
- Reuse `DATA_WIDTH; no new typedefs.
- Sub-module rr_pick (purely combinational): inputs req[NREQ] and ptr[IW]; outputs gnt_vld and gnt_idx[IW] using rotate–priority-encode–unrotate.
- stage_arb holds the counter, pointer, output registers and error flag.

Test Plan:
- Reset then ready_in=4'b0001, data 0x11, for 1 cycle -> credit_out=4'b0001 that cycle; next cycle ready_out=1, data_out=0x11, grant_id=0, credit_cnt=1.
- ready_in=4'b1111 held, credit_in pulsed every cycle -> grants cycle 0,1,2,3,0 with credit_out one-hot in that order; credit_cnt stays 2 after the first cycle's net -1+1.
- ready_in=4'b0110 held, no credit_in -> two grants (1 then 2), then credit_cnt=0 and credit_out=0, ready_out=0 until credit_in pulses; first grant after the pulse goes to 1.
- Simultaneous grant and credit_in at credit_cnt=1 -> grant issued, credit_cnt stays 1.
- credit_in pulse at credit_cnt=2 with ready_in=0 -> credit_cnt stays 2, err=1 and stays 1 until rst.
- rst asserted while credit_cnt=0 and ready_out=1 -> next cycle ready_out=0, data_out=0, credit_cnt=2; ready_in=4'b1000 then wins first (ptr=NREQ-1 wraps to 0, searches 0..3).
